pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Main decoder + ALU decoder for the 5-stage MIPS pipeline; produces the 3-bit ALUControl consumed by the ALU.
//  Decodes op/funct in D and carries control bits through the D->E, E->M and M->W pipeline registers.
//  Honours hazard-unit flushE; consumes ALU overflow in E.
// PARAMETERS
//  ALUC_W   3   ALUControl width; fixed at 3, other values unsupported
//  OP_W     6   opcode and funct field width; fixed at 6
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  opD          in   6   instr[31:26] in D
//  functD       in   6   instr[5:0] in D
//  equalD       in   1   branch comparator result in D
//  flushE       in   1   hazard unit: load NOP into the E register
//  overflowE    in   1   ALU overflow output in E
//  pcsrcD       out  1   branchD & equalD (combinational)
//  branchD      out  1   beq decoded (combinational)
//  jumpD        out  1   j decoded (combinational)
//  illegalD     out  1   unrecognised op/funct (combinational)
//  regwriteE/M/W    out 1  register-file write enable per stage
//  memtoregE/M/W    out 1  writeback select per stage
//  memwriteM        out 1  data-memory write enable
//  alusrcE          out 1  ALU B = immediate
//  regdstE          out 1  destination = rd
//  alucontrolE      out 3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//  ovf_excM         out 1  overflow exception flag in M (only with OVF_TRAP_EN)
// BEHAVIOUR
//  - Decode, combinational in D:
//    R-type (000000): regwrite=1, regdst=1; ALU op from funct.
//      100000 add -> 010, trap-checked. 100001 addu -> 010.
//      100010 sub -> 110, trap-checked. 100011 subu -> 110.
//      100100 -> 000. 100101 -> 001. 101010 -> 111.
//    lw 100011: regwrite, alusrc, memtoreg; ALU 010.
//    sw 101011: memwrite, alusrc; ALU 010.
//    beq 000100: branch; ALU 110.
//    addi 001000: regwrite, alusrc; ALU 010, trap-checked.
//    j 000010: jump; no other controls.
//  - Illegal op or R-type funct: every control 0 (NOP) and illegalD=1.
//  - Latency: D controls appear in E one cycle later, M two cycles later, W three cycles later.
//  - Pipeline registers have no enable; they advance every cycle. A D stall is realised by the hazard unit asserting flushE.
//  - flushE=1 at an edge: the E register loads all zeros (NOP), including ALU 000 and the check bit.
//    M and W still advance normally. flushE only affects the D->E transfer.
//  - Reset: all E/M/W registers and ovf_excM cleared to 0 asynchronously; D outputs follow inputs.
//    Reset asserted mid-stream discards all in-flight control.
//  - Reset deassertion: the first rising edge after release loads D normally.
// CONFIGURATION
//  OVF_TRAP_EN defined:
//    - A trap-checked instruction in E with overflowE=1 enters M with regwriteM=0 and ovf_excM=1.
//    - ovf_excM lasts one cycle; nothing propagates to W.
//    - addu, subu, lw, sw and beq never trap.
//  OVF_TRAP_EN undefined:
//    - overflowE ignored; ovf_excM tied to 0.
//    - The trap-check bit is not stored, so E/M register width shrinks by 1.
// TESTING
//  1. rst=1 mid-stream -> all E/M/W outputs 0 immediately, without waiting for clk.
//  2. R add (op 0, funct 20h) -> next cycle alucontrolE=010, regwriteE=1, regdstE=1.
//     The cycle after that: regwriteM=1. Then: regwriteW=1.
//  3. lw then sw, back to back -> alucontrolE=010 and alusrcE=1 on both.
//     memtoregM=1 (lw) followed by memwriteM=1 (sw).
//  4. beq with equalD=1 -> pcsrcD=1 in the same cycle, alucontrolE=110 next cycle.
//     With equalD=0 -> pcsrcD=0.
//  5. slt decoded while flushE=1 -> E register is all 0 (alucontrolE=000, regwriteE=0).
//     Next decode with flushE=0 enters E normally.
//  6. OVF_TRAP_EN: add in E with overflowE=1 -> regwriteM=0, ovf_excM=1 for one cycle.
//     addu with overflowE=1 -> regwriteM=1, ovf_excM=0.

Source files
------------

// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Main decoder and ALU decoder for the 5-stage MIPS pipeline. Decodes op/funct
//   in D. Carries the control bits through the D->E, E->M and M->W registers.
//
// Ports
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   opD, functD                   instr[31:26] and instr[5:0] in D
//   equalD                        branch comparator result in D
//   flushE                        loads a NOP into the E register
//   overflowE                     ALU overflow in E
//   pcsrcD, branchD, jumpD        combinational branch/jump decode in D
//   illegalD                      unrecognised op/funct in D; every control is forced to 0
//   regwriteE/M/W, memtoregE/M/W  per-stage writeback controls
//   memwriteM                     data-memory write enable
//   alusrcE, regdstE              ALU B source and destination select
//   alucontrolE                   000 and, 001 or, 010 add, 110 sub, 111 slt
//   ovf_excM                      overflow exception in M
//
// Configuration
//   OVF_TRAP_EN  When defined, a trap-checked instruction (add, sub, addi) that
//                overflows in E enters M with its register write cancelled and
//                ovf_excM set. When undefined, overflowE is ignored,
//                ovf_excM is held at 0 and the check bit is not stored.

module pipeline_controller #(
    parameter int ALUC_W = 3,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opD,
    input  logic [OP_W-1:0]   functD,
    input  logic              equalD,
    input  logic              flushE,
    input  logic              overflowE,
    output logic              pcsrcD,
    output logic              branchD,
    output logic              jumpD,
    output logic              illegalD,
    output logic              regwriteE,
    output logic              regwriteM,
    output logic              regwriteW,
    output logic              memtoregE,
    output logic              memtoregM,
    output logic              memtoregW,
    output logic              memwriteM,
    output logic              alusrcE,
    output logic              regdstE,
    output logic [ALUC_W-1:0] alucontrolE,
    output logic              ovf_excM
);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

    logic              regwriteD;
    logic              memtoregD;
    logic              memwriteD;
    logic              alusrcD;
    logic              regdstD;
    logic [ALUC_W-1:0] alucontrolD;
    logic              chkD;
    logic              memwriteE;

    // An unrecognised op or funct keeps the all-zero defaults, so it decodes as a NOP.
    always_comb begin
        regwriteD   = 1'b0;
        memtoregD   = 1'b0;
        memwriteD   = 1'b0;
        alusrcD     = 1'b0;
        regdstD     = 1'b0;
        alucontrolD = ALU_AND;
        chkD        = 1'b0;
        branchD     = 1'b0;
        jumpD       = 1'b0;
        illegalD    = 1'b0;
        case (opD)
            OP_RTYPE: begin
                regwriteD = 1'b1;
                regdstD   = 1'b1;
                case (functD)
                    6'b100000: begin alucontrolD = ALU_ADD; chkD = 1'b1; end
                    6'b100001: alucontrolD = ALU_ADD;
                    6'b100010: begin alucontrolD = ALU_SUB; chkD = 1'b1; end
                    6'b100011: alucontrolD = ALU_SUB;
                    6'b100100: alucontrolD = ALU_AND;
                    6'b100101: alucontrolD = ALU_OR;
                    6'b101010: alucontrolD = ALU_SLT;
                    default: begin
                        regwriteD = 1'b0;
                        regdstD   = 1'b0;
                        illegalD  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                regwriteD   = 1'b1;
                alusrcD     = 1'b1;
                memtoregD   = 1'b1;
                alucontrolD = ALU_ADD;
            end
            OP_SW: begin
                memwriteD   = 1'b1;
                alusrcD     = 1'b1;
                alucontrolD = ALU_ADD;
            end
            OP_BEQ: begin
                branchD     = 1'b1;
                alucontrolD = ALU_SUB;
            end
            OP_ADDI: begin
                regwriteD   = 1'b1;
                alusrcD     = 1'b1;
                alucontrolD = ALU_ADD;
                chkD        = 1'b1;
            end
            OP_J:    jumpD    = 1'b1;
            default: illegalD = 1'b1;
        endcase
    end

    assign pcsrcD = branchD & equalD;

`ifdef OVF_TRAP_EN
    logic chkE;
    logic trapE;

    assign trapE = chkE & overflowE;
`else
    logic trapE;
    logic unused_trap;

    // Without the trap feature, overflow never reaches the pipeline. The check
    // bit is decoded and then dropped here.
    assign trapE       = 1'b0;
    assign unused_trap = overflowE ^ chkD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwriteE   <= 1'b0;
            memtoregE   <= 1'b0;
            memwriteE   <= 1'b0;
            alusrcE     <= 1'b0;
            regdstE     <= 1'b0;
            alucontrolE <= '0;
`ifdef OVF_TRAP_EN
            chkE        <= 1'b0;
`endif
            regwriteM   <= 1'b0;
            memtoregM   <= 1'b0;
            memwriteM   <= 1'b0;
            ovf_excM    <= 1'b0;
            regwriteW   <= 1'b0;
            memtoregW   <= 1'b0;
        end else begin
            // flushE only affects the D->E transfer. M and W always advance.
            if (flushE) begin
                regwriteE   <= 1'b0;
                memtoregE   <= 1'b0;
                memwriteE   <= 1'b0;
                alusrcE     <= 1'b0;
                regdstE     <= 1'b0;
                alucontrolE <= '0;
`ifdef OVF_TRAP_EN
                chkE        <= 1'b0;
`endif
            end else begin
                regwriteE   <= regwriteD;
                memtoregE   <= memtoregD;
                memwriteE   <= memwriteD;
                alusrcE     <= alusrcD;
                regdstE     <= regdstD;
                alucontrolE <= alucontrolD;
`ifdef OVF_TRAP_EN
                chkE        <= chkD;
`endif
            end
            // A trapped instruction loses its register write. The exception
            // flag is held in M only and does not travel on to W.
            regwriteM <= regwriteE & ~trapE;
            memtoregM <= memtoregE;
            memwriteM <= memwriteE;
            ovf_excM  <= trapE;
            regwriteW <= regwriteM;
            memtoregW <= memtoregM;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opD = 6'd0;
    logic [5:0] functD = 6'd0;
    logic       equalD = 1'b0;
    logic       flushE = 1'b0;
    logic       overflowE = 1'b0;
    logic       pcsrcD, branchD, jumpD, illegalD;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM, memtoregW;
    logic       memwriteM, alusrcE, regdstE, ovf_excM;
    logic [2:0] alucontrolE;

    pipeline_controller dut (
        .clk(clk), .rst(rst), .opD(opD), .functD(functD), .equalD(equalD),
        .flushE(flushE), .overflowE(overflowE),
        .pcsrcD(pcsrcD), .branchD(branchD), .jumpD(jumpD), .illegalD(illegalD),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
        .memwriteM(memwriteM), .alusrcE(alusrcE), .regdstE(regdstE),
        .alucontrolE(alucontrolE), .ovf_excM(ovf_excM)
    );

    always #5 clk = ~clk;

`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       rw, mtr, mw, as, rd;
        logic [2:0] alu;
        logic       chk, br, jmp, ill;
    } ctrl_t;

    int total = 0;
    int bad = 0;

    // Reference model: one instruction record per stage.
    ctrl_t ex_i, mem_i, wb_i;
    logic  mem_ovf;

    function automatic ctrl_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        if (op == 6'h00) begin
            c.rw = 1'b1; c.rd = 1'b1;
            if      (fn == 6'h20) begin c.alu = 3'b010; c.chk = 1'b1; end
            else if (fn == 6'h21) c.alu = 3'b010;
            else if (fn == 6'h22) begin c.alu = 3'b110; c.chk = 1'b1; end
            else if (fn == 6'h23) c.alu = 3'b110;
            else if (fn == 6'h24) c.alu = 3'b000;
            else if (fn == 6'h25) c.alu = 3'b001;
            else if (fn == 6'h2A) c.alu = 3'b111;
            else begin c = '0; c.ill = 1'b1; end
        end
        else if (op == 6'h23) begin c.rw = 1'b1; c.as = 1'b1; c.mtr = 1'b1; c.alu = 3'b010; end
        else if (op == 6'h2B) begin c.mw = 1'b1; c.as = 1'b1; c.alu = 3'b010; end
        else if (op == 6'h04) begin c.br = 1'b1; c.alu = 3'b110; end
        else if (op == 6'h08) begin c.rw = 1'b1; c.as = 1'b1; c.alu = 3'b010; c.chk = 1'b1; end
        else if (op == 6'h02) c.jmp = 1'b1;
        else c.ill = 1'b1;
        return c;
    endfunction

    task automatic model_clear();
        ex_i = '0; mem_i = '0; wb_i = '0; mem_ovf = 1'b0;
    endtask

    // Applies one rising edge to the model, using the inputs present at that edge.
    task automatic tick();
        logic trap;
        @(posedge clk);
        if (rst) model_clear();
        else begin
            trap    = TRAP && ex_i.chk && overflowE;
            wb_i    = mem_i;
            mem_i   = ex_i;
            mem_ovf = trap;
            if (trap) mem_i.rw = 1'b0;
            ex_i    = flushE ? ctrl_t'('0) : ref_dec(opD, functD);
        end
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opD = op; functD = fn; flushE = 1'b0; overflowE = 1'b0; equalD = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW,
             memwriteM, alusrcE, regdstE, alucontrolE, ovf_excM} !== 12'd0) begin
            bad++;
            $display("FAIL reset_state got=%b want=0", {regwriteE, regwriteM, regwriteW,
                     memtoregE, memtoregM, memtoregW, memwriteM, alusrcE, regdstE,
                     alucontrolE, ovf_excM});
        end
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        set_instr(6'h00, 6'h20);
        tick();
        total++;
        if ({alucontrolE, regwriteE, regdstE} !== 5'b01011) begin
            bad++;
            $display("FAIL add_E got=%b want=01011", {alucontrolE, regwriteE, regdstE});
        end
        set_instr(6'h3F, 6'h00);
        tick();
        total++;
        if (regwriteM !== 1'b1) begin bad++; $display("FAIL add_M got=%b want=1", regwriteM); end
        tick();
        total++;
        if (regwriteW !== 1'b1) begin bad++; $display("FAIL add_W got=%b want=1", regwriteW); end
    endtask

    task automatic test_back_to_back();
        set_instr(6'h23, 6'h00);
        tick();
        total++;
        if ({alucontrolE, alusrcE} !== 4'b0101) begin
            bad++; $display("FAIL lw_E got=%b want=0101", {alucontrolE, alusrcE});
        end
        set_instr(6'h2B, 6'h00);
        tick();
        total++;
        if ({alucontrolE, alusrcE, memtoregM} !== 5'b01011) begin
            bad++; $display("FAIL sw_E_lw_M got=%b want=01011", {alucontrolE, alusrcE, memtoregM});
        end
        set_instr(6'h3F, 6'h00);
        tick();
        total++;
        if ({memwriteM, memtoregM} !== 2'b10) begin
            bad++; $display("FAIL sw_M got=%b want=10", {memwriteM, memtoregM});
        end
    endtask

    task automatic test_beq();
        set_instr(6'h04, 6'h00);
        equalD = 1'b1;
        #1;
        total++;
        if ({pcsrcD, branchD} !== 2'b11) begin
            bad++; $display("FAIL beq_taken got=%b want=11", {pcsrcD, branchD});
        end
        tick();
        total++;
        if (alucontrolE !== 3'b110) begin bad++; $display("FAIL beq_E got=%b want=110", alucontrolE); end
        equalD = 1'b0;
        #1;
        total++;
        if ({pcsrcD, branchD} !== 2'b01) begin
            bad++; $display("FAIL beq_not_taken got=%b want=01", {pcsrcD, branchD});
        end
        tick();
    endtask

    task automatic test_flush();
        set_instr(6'h00, 6'h2A);
        flushE = 1'b1;
        tick();
        total++;
        if ({regwriteE, memtoregE, alusrcE, regdstE, alucontrolE} !== 7'd0) begin
            bad++; $display("FAIL flush_E got=%b want=0", {regwriteE, memtoregE, alusrcE, regdstE, alucontrolE});
        end
        flushE = 1'b0;
        tick();
        total++;
        if ({alucontrolE, regwriteE} !== 4'b1111) begin
            bad++; $display("FAIL after_flush_E got=%b want=1111", {alucontrolE, regwriteE});
        end
    endtask

    task automatic test_overflow(input logic [5:0] fn, input logic trapped);
        logic exp_rw;
        exp_rw = ~(TRAP && trapped);
        set_instr(6'h00, fn);
        tick();
        set_instr(6'h3F, 6'h00);
        overflowE = 1'b1;
        tick();
        overflowE = 1'b0;
        total++;
        if ({regwriteM, ovf_excM} !== {exp_rw, ~exp_rw}) begin
            bad++; $display("FAIL ovf_M fn=%h got=%b want=%b", fn, {regwriteM, ovf_excM}, {exp_rw, ~exp_rw});
        end
        tick();
        total++;
        if ({regwriteW, ovf_excM} !== {exp_rw, 1'b0}) begin
            bad++; $display("FAIL ovf_W fn=%h got=%b want=%b", fn, {regwriteW, ovf_excM}, {exp_rw, 1'b0});
        end
    endtask

    task automatic drive_random();
        int k;
        k = $urandom_range(0, 13);
        functD = 6'($urandom);
        case (k)
            0: begin opD = 6'h00; functD = 6'h20; end
            1: begin opD = 6'h00; functD = 6'h21; end
            2: begin opD = 6'h00; functD = 6'h22; end
            3: begin opD = 6'h00; functD = 6'h23; end
            4: begin opD = 6'h00; functD = 6'h24; end
            5: begin opD = 6'h00; functD = 6'h25; end
            6: begin opD = 6'h00; functD = 6'h2A; end
            7: opD = 6'h23;
            8: opD = 6'h2B;
            9: opD = 6'h04;
            10: opD = 6'h08;
            11: opD = 6'h02;
            12: opD = 6'h00;
            default: opD = 6'($urandom);
        endcase
        equalD    = 1'($urandom);
        flushE    = ($urandom_range(0, 4) == 0);
        overflowE = 1'($urandom);
    endtask

    task automatic test_random(input int n);
        ctrl_t d;
        for (int i = 0; i < n; i++) begin
            drive_random();
            #1;
            d = ref_dec(opD, functD);
            total++;
            if ({pcsrcD, branchD, jumpD, illegalD} !== {d.br & equalD, d.br, d.jmp, d.ill}) begin
                bad++; $display("FAIL rand_D op=%h fn=%h got=%b want=%b", opD, functD,
                    {pcsrcD, branchD, jumpD, illegalD}, {d.br & equalD, d.br, d.jmp, d.ill});
            end
            tick();
            total++;
            if ({regwriteE, memtoregE, alusrcE, regdstE, alucontrolE} !==
                {ex_i.rw, ex_i.mtr, ex_i.as, ex_i.rd, ex_i.alu}) begin
                bad++; $display("FAIL rand_E got=%b want=%b",
                    {regwriteE, memtoregE, alusrcE, regdstE, alucontrolE},
                    {ex_i.rw, ex_i.mtr, ex_i.as, ex_i.rd, ex_i.alu});
            end
            total++;
            if ({regwriteM, memtoregM, memwriteM, ovf_excM, regwriteW, memtoregW} !==
                {mem_i.rw, mem_i.mtr, mem_i.mw, mem_ovf, wb_i.rw, wb_i.mtr}) begin
                bad++; $display("FAIL rand_MW got=%b want=%b",
                    {regwriteM, memtoregM, memwriteM, ovf_excM, regwriteW, memtoregW},
                    {mem_i.rw, mem_i.mtr, mem_i.mw, mem_ovf, wb_i.rw, wb_i.mtr});
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_instr(6'h23, 6'h00);
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        total++;
        if ({regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW,
             memwriteM, alusrcE, regdstE, alucontrolE, ovf_excM} !== 12'd0) begin
            bad++;
            $display("FAIL reset_midstream got=%b want=0", {regwriteE, regwriteM, regwriteW,
                     memtoregE, memtoregM, memtoregW, memwriteM, alusrcE, regdstE,
                     alucontrolE, ovf_excM});
        end
        #1;
        rst = 1'b0;
        set_instr(6'h00, 6'h22);
        tick();
        total++;
        if ({alucontrolE, regwriteE, regwriteM} !== 5'b11010) begin
            bad++; $display("FAIL first_after_reset got=%b want=11010", {alucontrolE, regwriteE, regwriteM});
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_beq();
        test_flush();
        test_overflow(6'h20, 1'b1);
        test_overflow(6'h21, 1'b0);
        test_overflow(6'h22, 1'b1);
        test_overflow(6'h23, 1'b0);
        test_random(400);
        test_reset_midstream();
        test_random(200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
